// File: rtl/edge_det_pkg.sv
// Shared definitions for the debounced edge detector.
// Trigger mode encoding and the edge qualification helper.
package edge_det_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10,
        BOTH = 2'b11
    } edge_mode_e;

    function automatic logic edge_hit(
        input edge_mode_e m,
        input logic       rise,
        input logic       fall
    );
        logic [1:0] mv;
        mv = m;
        return (rise & mv[0]) | (fall & mv[1]);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One channel: synchronizer, debounce counter, accepted level,
// registered edge pulse and sticky pending/overflow flags.
module debounce_ch
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4,
    parameter bit          RST_VAL     = 1'b0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       async_in,
    input  edge_mode_e mode,
    input  logic       clear,
    output logic       sync_out,
    output logic       edge_pulse,
    output logic       edge_pending,
    output logic       overflow
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise;
    logic                   fall;
    logic                   pulse_d;
    logic                   pend_d;
    logic                   ovf_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // The counter only runs while synced disagrees with the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = synced;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign rise    = level_d & ~level_q;
    assign fall    = ~level_d & level_q;
    assign pulse_d = edge_hit(mode, rise, fall);

    // A pulse in the same cycle as clear still sets pending and wins.
    assign pend_d = edge_pulse | (edge_pending & ~clear);
    assign ovf_d  = ~clear & (overflow | (edge_pulse & edge_pending));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q        <= '0;
            level_q      <= RST_VAL;
            edge_pulse   <= 1'b0;
            edge_pending <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            edge_pulse   <= pulse_d;
            edge_pending <= pend_d;
            overflow     <= ovf_d;
        end
    end

    assign sync_out = level_q;

endmodule

// File: rtl/debounce_edge_det.sv
// Multi-channel debounced edge detector with sticky edge flags.
// Each channel is an independent debounce_ch instance.
module debounce_edge_det
    import edge_det_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4,
    parameter bit          RST_VAL     = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_CH-1:0]   async_in,
    input  logic [2*NUM_CH-1:0] mode,
    input  logic [NUM_CH-1:0]   clear,
    output logic [NUM_CH-1:0]   sync_out,
    output logic [NUM_CH-1:0]   edge_pulse,
    output logic [NUM_CH-1:0]   edge_pending,
    output logic [NUM_CH-1:0]   overflow
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        edge_mode_e ch_mode;

        assign ch_mode = edge_mode_e'(mode[2*gi +: 2]);

        debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .RST_VAL     (RST_VAL)
        ) u_ch (
            .clk          (clk),
            .n_rst        (n_rst),
            .async_in     (async_in[gi]),
            .mode         (ch_mode),
            .clear        (clear[gi]),
            .sync_out     (sync_out[gi]),
            .edge_pulse   (edge_pulse[gi]),
            .edge_pending (edge_pending[gi]),
            .overflow     (overflow[gi])
        );
    end

endmodule

// File: tb/tb_debounce_edge_det.sv
// Bench for debounce_edge_det: window-based reference model
// compared every cycle, plus hand-computed directed checks.
module tb_debounce_edge_det;

    localparam int NCH  = 4;
    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic [NCH-1:0] async_in = '0;
    logic [2*NCH-1:0] mode = '0;
    logic [NCH-1:0] clear = '0;
    logic [NCH-1:0] sync_out;
    logic [NCH-1:0] edge_pulse;
    logic [NCH-1:0] edge_pending;
    logic [NCH-1:0] overflow;

    int checks = 0;
    int failures = 0;

    debounce_edge_det #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (SYNC),
        .DB_CYCLES   (DB),
        .RST_VAL     (1'b0)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .async_in     (async_in),
        .mode         (mode),
        .clear        (clear),
        .sync_out     (sync_out),
        .edge_pulse   (edge_pulse),
        .edge_pending (edge_pending),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h want %0h",
                     name, $time, act, exp);
        end
    endtask

    // Reference: the counter sees the input sampled SYNC edges earlier;
    // the level flips once the last DB seen samples all disagree with it.
    bit dq  [NCH][$];
    bit win [NCH][$];
    bit [NCH-1:0] m_lvl, m_pulse, m_pend, m_ovf;

    always @(posedge clk or negedge n_rst) begin : model
        bit seen;
        bit tmp;
        bit flip;
        bit hit;
        bit old_pulse;
        if (!n_rst) begin
            for (int c = 0; c < NCH; c++) begin
                dq[c].delete();
                win[c].delete();
                for (int k = 0; k < SYNC; k++) dq[c].push_back(1'b0);
            end
            m_lvl   = '0;
            m_pulse = '0;
            m_pend  = '0;
            m_ovf   = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                seen = dq[c].pop_front();
                dq[c].push_back(async_in[c]);
                win[c].push_back(seen);
                if (win[c].size() > DB) tmp = win[c].pop_front();
                flip = (win[c].size() == DB);
                for (int k = 0; k < win[c].size(); k++)
                    if (win[c][k] == m_lvl[c]) flip = 1'b0;
                old_pulse = m_pulse[c];
                hit = 1'b0;
                if (flip) begin
                    hit = m_lvl[c] ? mode[2*c+1] : mode[2*c];
                    m_lvl[c] = ~m_lvl[c];
                    win[c].delete();
                end
                m_ovf[c]   = clear[c] ? 1'b0
                           : (m_ovf[c] | (old_pulse & m_pend[c]));
                m_pend[c]  = old_pulse | (m_pend[c] & ~clear[c]);
                m_pulse[c] = hit;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_sync_out", 32'(sync_out), 32'(m_lvl));
        chk("model_edge_pulse", 32'(edge_pulse), 32'(m_pulse));
        chk("model_edge_pending", 32'(edge_pending), 32'(m_pend));
        chk("model_overflow", 32'(overflow), 32'(m_ovf));
    end

    task automatic wait_count(input int n, input int ch, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (edge_pulse[ch]) cnt++;
        end
    endtask

    logic [23:0] glitch_vec;
    int n;

    initial begin
        mode = 8'b11_01_11_01;
        repeat (3) @(negedge clk);
        chk("rst_sync_out", 32'(sync_out), 0);
        chk("rst_edge_pulse", 32'(edge_pulse), 0);
        chk("rst_pending", 32'(edge_pending), 0);
        chk("rst_overflow", 32'(overflow), 0);
        #2 n_rst = 1'b1;

        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (edge_pulse != 0) n++;
        end
        chk("idle_no_pulse", 32'(n), 0);
        chk("idle_sync_out", 32'(sync_out), 0);

        // ch0 rise: level appears on the 6th edge
        async_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("ch0_edge5_level", 32'(sync_out[0]), 0);
        @(negedge clk);
        chk("ch0_edge6_level", 32'(sync_out[0]), 1);
        chk("ch0_edge6_pulse", 32'(edge_pulse[0]), 1);
        @(negedge clk);
        chk("ch0_pulse_one_cycle", 32'(edge_pulse[0]), 0);
        chk("ch0_pending", 32'(edge_pending[0]), 1);

        // ch2 short glitch
        async_in[2] = 1'b1;
        repeat (3) @(negedge clk);
        async_in[2] = 1'b0;
        wait_count(12, 2, n);
        chk("ch2_glitch_pulses", 32'(n), 0);
        chk("ch2_glitch_level", 32'(sync_out[2]), 0);
        chk("ch2_glitch_pending", 32'(edge_pending[2]), 0);

        // ch1 both edges, no clear -> overflow
        async_in[1] = 1'b1;
        wait_count(10, 1, n);
        begin
            int n2;
            async_in[1] = 1'b0;
            wait_count(10, 1, n2);
            n += n2;
        end
        chk("ch1_two_pulses", 32'(n), 2);
        chk("ch1_pending", 32'(edge_pending[1]), 1);
        chk("ch1_overflow", 32'(overflow[1]), 1);
        clear[1] = 1'b1;
        @(negedge clk);
        clear[1] = 1'b0;
        chk("ch1_clr_pending", 32'(edge_pending[1]), 0);
        chk("ch1_clr_overflow", 32'(overflow[1]), 0);

        // ch3 clear coincident with pulse
        async_in[3] = 1'b1;
        repeat (6) @(negedge clk);
        chk("ch3_rise_pulse", 32'(edge_pulse[3]), 1);
        clear[3] = 1'b1;
        @(negedge clk);
        clear[3] = 1'b0;
        chk("ch3_set_wins", 32'(edge_pending[3]), 1);
        chk("ch3_no_ovf", 32'(overflow[3]), 0);
        async_in[3] = 1'b0;
        repeat (6) @(negedge clk);
        chk("ch3_fall_pulse", 32'(edge_pulse[3]), 1);
        clear[3] = 1'b1;
        @(negedge clk);
        clear[3] = 1'b0;
        chk("ch3_set_wins2", 32'(edge_pending[3]), 1);
        chk("ch3_no_ovf2", 32'(overflow[3]), 0);

        // ch2 mode none, then fall-only
        mode[5:4] = 2'b00;
        async_in[2] = 1'b1;
        wait_count(10, 2, n);
        chk("ch2_none_pulses", 32'(n), 0);
        chk("ch2_none_level", 32'(sync_out[2]), 1);
        mode[5:4] = 2'b10;
        async_in[2] = 1'b0;
        wait_count(10, 2, n);
        chk("ch2_fall_pulses", 32'(n), 1);

        // all channels toggle together
        mode = 8'hFF;
        clear = 4'hF;
        @(negedge clk);
        clear = 4'h0;
        async_in = ~async_in;
        repeat (6) @(negedge clk);
        chk("all_pulse", 32'(edge_pulse), 32'hF);
        @(negedge clk);
        chk("all_pending", 32'(edge_pending), 32'hF);

        // bouncy input on ch1
        glitch_vec = 24'b0011_1101_0111_1011_0010_1100;
        for (int k = 0; k < 24; k++) begin
            async_in[1] = glitch_vec[k];
            @(negedge clk);
        end
        repeat (10) @(negedge clk);

        // reset in the middle of a ch0 debounce
        async_in = 4'h0;
        repeat (12) @(negedge clk);
        async_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b1;
        wait_count(5, 0, n);
        chk("rstmid_no_pulse", 32'(n), 0);
        chk("rstmid_edge5", 32'(sync_out[0]), 0);
        @(negedge clk);
        chk("rstmid_edge6", 32'(sync_out[0]), 1);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_edge_det.md
DEBOUNCE_EDGE_DET -- requirements
Module: debounce_edge_det

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent input channels (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop depth per channel (>=2).
REQ-003 SHALL have parameter DB_CYCLES, default 4, consecutive cycles of a new level required to accept it (>=1).
REQ-004 SHALL have parameter RST_VAL, default 0, reset value of every synchronizer flop and every debounced level.
REQ-005 SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-006 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port async_in  input  NUM_CH  asynchronous raw inputs.
REQ-008 SHALL have port mode  input  2*NUM_CH  per-channel trigger mode, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both.
REQ-009 SHALL have port clear  input  NUM_CH  per-channel synchronous clear of the sticky flags.
REQ-010 SHALL have port sync_out  output  NUM_CH  debounced synchronized level.
REQ-011 SHALL have port edge_pulse  output  NUM_CH  one-cycle registered pulse per qualifying accepted edge.
REQ-012 SHALL have port edge_pending  output  NUM_CH  sticky flag, set by edge_pulse.
REQ-013 SHALL have port overflow  output  NUM_CH  sticky flag, set by an edge_pulse while edge_pending is already 1.

Function
REQ-014 Each channel SHALL pass async_in through a SYNC_STAGES-deep flop chain; the last stage is "synced".
REQ-015 Debounce counter width SHALL be $clog2(DB_CYCLES+1); the counter clears whenever synced equals the debounced level.
REQ-016 When synced differs from level and the counter equals DB_CYCLES-1, level SHALL take synced and the counter SHALL clear; otherwise the counter SHALL increment.
REQ-017 sync_out SHALL equal level; a clean input change SHALL appear on sync_out on the (SYNC_STAGES+DB_CYCLES)th rising clk edge after the change.
REQ-018 A glitch shorter than DB_CYCLES synced cycles SHALL leave level, edge_pulse and all flags unchanged.
REQ-019 edge_pulse[i] SHALL assert in the same cycle level[i] changes, for exactly one cycle, only if mode[i] selects that direction (rise 0->1, fall 1->0).
REQ-020 Mode 00 SHALL suppress edge_pulse while level still tracks the input; a mode change SHALL take effect on the next level update.
REQ-021 edge_pulse SHALL set edge_pending; clear SHALL reset edge_pending and overflow on the next edge.
REQ-022 Simultaneous clear and edge_pulse SHALL leave edge_pending=1 and overflow=0 (set wins over clear).
REQ-023 edge_pulse with edge_pending=1 and clear=0 SHALL set overflow; edge_pending stays 1.
REQ-024 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each be reported in the same cycle.

Reset
REQ-025 n_rst low SHALL asynchronously force synchronizer flops and level to RST_VAL, counters to 0, and edge_pulse, edge_pending, overflow to 0.
REQ-026 Reset mid-debounce SHALL discard the partial count; after release no edge_pulse SHALL occur unless the input differs from RST_VAL for a full debounce period.
REQ-027 Outputs SHALL be valid from the first clk edge after n_rst rises.

Structure
REQ-028 Mode encoding (typedef of 2-bit enum: NONE, RISE, FALL, BOTH) SHALL live in shared package edge_det_pkg.
REQ-029 Per-channel logic (synchronizer, debounce counter, level, edge and flag flops) SHALL be one sub-module debounce_ch, instantiated NUM_CH times by a generate loop.
REQ-030 No combinational path SHALL exist from async_in to any output.

Verification (NUM_CH=4, SYNC_STAGES=2, DB_CYCLES=4, RST_VAL=0)
REQ-031 Assert reset -> all outputs 0; release with async_in=4'b0000 -> no pulses for 20 cycles.
REQ-032 mode[1:0]=01, async_in[0] 0->1 held -> sync_out[0]=1 on 6th edge, edge_pulse[0] one cycle, edge_pending[0]=1.
REQ-033 async_in[2] high for 3 cycles then low -> sync_out[2], edge_pulse[2], edge_pending[2] stay 0.
REQ-034 mode[3:2]=11, async_in[1] rise then fall 10 cycles later, no clear -> two pulses, overflow[1]=1; clear[1] -> both flags 0.
REQ-035 clear[3] asserted in the edge_pulse[3] cycle -> edge_pending[3]=1, overflow[3]=0.
REQ-036 n_rst pulsed low 2 cycles into a debounce on ch0 -> no edge_pulse; sync_out[0] rises 6 edges after release if input still 1.
